branch_predict_unit: RTL and testbench

Parametrised branch resolution and prediction block for the RISC-V core, replacing the combinational branch unit. The fetch stage looks up a predicted direction and target from a direct-mapped BHT/BTB indexed by PC. The execute stage resolves B-type, JAL and JALR using ALU flags. Mispredictions produce a registered one-cycle redirect, and the tables train on every resolved control-flow instruction.

---
 rtl/branch_predict_unit.sv | 138 +++++++++++++
 tb/tb_branch_predict_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution plus a direct-mapped BHT/BTB predictor with a registered mispredict redirect.
// Optional performance counters are built only when BRANCH_PERF_EN is defined.
module branch_predict_unit #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] f_pc,
   output logic            f_pred_taken,
   output logic [XLEN-1:0] f_pred_target,
   input  logic            ex_valid,
   input  logic            ex_br,
   input  logic            ex_j,
   input  logic            ex_jr,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_zero,
   input  logic            ex_neg,
   input  logic            ex_overflow,
   input  logic            ex_carry,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic [XLEN-1:0] ex_pred_target,
   output logic            PCsrc,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic [31:0]     perf_branches,
   output logic [31:0]     perf_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [1:0]       ctr        [BHT_ENTRIES];
   logic             btb_valid  [BHT_ENTRIES];
   logic [TAG_W-1:0] btb_tag    [BHT_ENTRIES];
   logic [XLEN-1:0]  btb_target [BHT_ENTRIES];

   logic [IDX_W-1:0] f_idx, ex_idx;
   logic [TAG_W-1:0] f_tag, ex_tag;
   logic             unused_pc_bits;

   assign f_idx  = f_pc[IDX_W+1:2];
   assign f_tag  = f_pc[XLEN-1:IDX_W+2];
   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
   // Instructions are word aligned, so the byte offset never selects an entry.
   assign unused_pc_bits = ^f_pc[1:0];

   assign f_pred_taken  = btb_valid[f_idx] & (btb_tag[f_idx] == f_tag) & ctr[f_idx][1];
   assign f_pred_target = btb_target[f_idx];

   logic cond, legal, taken, cf, ex_valid_eff, mispredict, upd;
   logic slt, ult;
   logic [1:0] cur_ctr, sat_inc, sat_dec;

   assign slt = ex_neg ^ ex_overflow;
   assign ult = ~ex_carry;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      cond  = 1'b0;
      legal = 1'b1;
      case (ex_funct3)
         3'b000:  cond = ex_zero;
         3'b001:  cond = ~ex_zero;
         3'b100:  cond = slt;
         3'b101:  cond = ~slt;
         3'b110:  cond = ult;
         3'b111:  cond = ~ult;
         default: legal = 1'b0;
      endcase
   end

   assign cf           = ex_br | ex_j | ex_jr;
   assign ex_valid_eff = ex_valid & ~redirect_valid;
   assign taken        = ex_j | ex_jr | (ex_br & legal & cond);
   assign PCsrc        = ex_valid_eff & taken;
   assign mispredict   = ex_valid_eff & cf &
                         ((taken != ex_pred_taken) | (taken & (ex_pred_target != ex_target)));
   assign upd          = ex_valid_eff & cf & (~ex_br | legal);

   assign cur_ctr = ctr[ex_idx];
   assign sat_inc = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
   assign sat_dec = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;

   // NOTE: the tables are reset as flops because a defined weakly-not-taken, invalid start is part of the contract.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctr            <= '{default: 2'b01};
         btb_valid      <= '{default: 1'b0};
         btb_tag        <= '{default: '0};
         btb_target     <= '{default: '0};
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= mispredict;
         if (mispredict)
            redirect_pc <= taken ? ex_target : ex_pc + XLEN'(4);
         if (upd) begin
            if (ex_br)
               ctr[ex_idx] <= taken ? sat_inc : sat_dec;
            else
               ctr[ex_idx] <= 2'b11;
            // A not-taken branch leaves the BTB alone, so an aliasing entry survives.
            if (taken) begin
               btb_valid[ex_idx]  <= 1'b1;
               btb_tag[ex_idx]    <= ex_tag;
               btb_target[ex_idx] <= ex_target;
            end
         end
      end
   end

`ifdef BRANCH_PERF_EN
   logic [31:0] br_cnt, mis_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         br_cnt  <= '0;
         mis_cnt <= '0;
      end else begin
         if (ex_valid_eff & cf)
            br_cnt <= br_cnt + 32'd1;
         if (mispredict)
            mis_cnt <= mis_cnt + 32'd1;
      end
   end

   assign perf_branches    = br_cnt;
   assign perf_mispredicts = mis_cnt;
`else
   assign perf_branches    = '0;
   assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomized scoreboard bench for branch_predict_unit against an operand-level reference model.
// Perf expectations follow BRANCH_PERF_EN the same way the design does.
module tb_branch_predict_unit;

   localparam int XLEN  = 32;
   localparam int N     = 64;
   localparam int IDX_W = 6;

   logic            clk = 1'b0;
   logic            rst;
   logic [XLEN-1:0] f_pc;
   logic            f_pred_taken;
   logic [XLEN-1:0] f_pred_target;
   logic            ex_valid, ex_br, ex_j, ex_jr;
   logic [2:0]      ex_funct3;
   logic            ex_zero, ex_neg, ex_overflow, ex_carry;
   logic [XLEN-1:0] ex_pc, ex_target, ex_pred_target;
   logic            ex_pred_taken;
   logic            PCsrc, redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     perf_branches, perf_mispredicts;

   branch_predict_unit #(.XLEN(XLEN), .BHT_ENTRIES(N)) dut (
      .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .f_pred_target(f_pred_target), .ex_valid(ex_valid), .ex_br(ex_br), .ex_j(ex_j),
      .ex_jr(ex_jr), .ex_funct3(ex_funct3), .ex_zero(ex_zero), .ex_neg(ex_neg),
      .ex_overflow(ex_overflow), .ex_carry(ex_carry), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .PCsrc(PCsrc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: the predictor as plain arrays and integers.
   int          m_ctr [N];
   bit          m_val [N];
   logic [31:0] m_tag [N];
   logic [31:0] m_tgt [N];
   bit          m_rv;
   logic [31:0] m_nbr, m_nmis;

   typedef struct {
      bit          pcsrc;
      bit          ptaken;
      logic [31:0] ptgt;
      logic [31:0] nbr;
      logic [31:0] nmis;
   } comb_t;
   typedef struct {
      logic [31:0] pc;
      int          due;
   } redir_t;

   comb_t  cq[$];
   redir_t rq[$];

   function automatic int m_idx(input logic [31:0] pc);
      return int'((pc >> 2) % N);
   endfunction

   function automatic logic [31:0] m_tagof(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bit m_pred(input logic [31:0] pc);
      int i = m_idx(pc);
      return m_val[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
   endfunction

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin
         m_ctr[i] = 1;
         m_val[i] = 1'b0;
         m_tag[i] = '0;
         m_tgt[i] = '0;
      end
      m_rv   = 1'b0;
      m_nbr  = '0;
      m_nmis = '0;
   endtask

   // One clock cycle: drive inputs, predict every output, advance the model past the edge.
   task automatic step(input bit r, input bit v, input bit b, input bit jj, input bit jr,
                       input logic [2:0] f3, input logic [31:0] a, input logic [31:0] c,
                       input logic [31:0] pc, input logic [31:0] tg, input bit pt,
                       input logic [31:0] ptg, input logic [31:0] fpc);
      logic [31:0] diff;
      bit          legal, cond, taken, eff, cf, mis;
      comb_t       ce;
      int          i;
      diff = a - c;
      rst = r; ex_valid = v; ex_br = b; ex_j = jj; ex_jr = jr; ex_funct3 = f3;
      ex_zero = (diff == 0);
      ex_neg = diff[31];
      ex_overflow = (a[31] != c[31]) && (diff[31] != a[31]);
      ex_carry = (a >= c);
      ex_pc = pc; ex_target = tg; ex_pred_taken = pt; ex_pred_target = ptg; f_pc = fpc;

      legal = 1'b1;
      case (f3)
         3'd0:    cond = (a == c);
         3'd1:    cond = (a != c);
         3'd4:    cond = ($signed(a) < $signed(c));
         3'd5:    cond = ($signed(a) >= $signed(c));
         3'd6:    cond = (a < c);
         3'd7:    cond = (a >= c);
         default: begin cond = 1'b0; legal = 1'b0; end
      endcase
      cf    = b || jj || jr;
      eff   = v && !m_rv;
      taken = jj || jr || (b && legal && cond);
      mis   = eff && cf && ((taken != pt) || (taken && ptg != tg));

      ce.pcsrc  = eff && taken;
      ce.ptaken = m_pred(fpc);
      ce.ptgt   = m_tgt[m_idx(fpc)];
`ifdef BRANCH_PERF_EN
      ce.nbr  = m_nbr;
      ce.nmis = m_nmis;
`else
      ce.nbr  = '0;
      ce.nmis = '0;
`endif
      cq.push_back(ce);

      if (r) begin
         m_reset();
      end else begin
         if (mis) rq.push_back('{pc: (taken ? tg : pc + 32'd4), due: cyc + 1});
         if (eff && cf) m_nbr = m_nbr + 32'd1;
         if (mis) m_nmis = m_nmis + 32'd1;
         if (eff && cf && (!b || legal)) begin
            i = m_idx(pc);
            if (b) m_ctr[i] = taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                                    : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
            else   m_ctr[i] = 3;
            if (taken) begin
               m_val[i] = 1'b1;
               m_tag[i] = m_tagof(pc);
               m_tgt[i] = tg;
            end
         end
         m_rv = mis;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] fpc);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, fpc);
   endtask

   task automatic branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] c,
                         input logic [31:0] pc, input logic [31:0] tg);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, f3, a, c, pc, tg, m_pred(pc), m_tgt[m_idx(pc)], pc);
      idle(pc);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents its per-cycle and redirect outputs.
   always @(negedge clk) begin
      if (cq.size() > 0) begin
         comb_t e;
         e = cq.pop_front();
         check("pcsrc", 64'(PCsrc), 64'(e.pcsrc));
         check("pred_taken", 64'(f_pred_taken), 64'(e.ptaken));
         check("pred_target", 64'(f_pred_target), 64'(e.ptgt));
         check("perf_branches", 64'(perf_branches), 64'(e.nbr));
         check("perf_mispredicts", 64'(perf_mispredicts), 64'(e.nmis));
      end
      if (redirect_valid) begin
         if (rq.size() == 0) begin
            check("redirect_unexpected", 64'(redirect_valid), 64'(0));
         end else begin
            redir_t r;
            r = rq.pop_front();
            check("redirect_pc", 64'(redirect_pc), 64'(r.pc));
            check("redirect_cycle", 64'(cyc), 64'(r.due));
         end
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
         check("redirect_missing", 64'(redirect_valid), 64'(1));
         void'(rq.pop_front());
      end
   end

   logic [31:0] tgt_set [4] = '{32'h140, 32'h480, 32'h400, 32'h240};
   logic [31:0] opd_set [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

   function automatic logic [31:0] rand_pc();
      logic [31:0] p = 32'h100 + 32'(4 * $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) p = p + 32'(4 * N);
      return p;
   endfunction

   function automatic logic [31:0] rand_opd();
      int k = $urandom_range(0, 5);
      return (k == 5) ? $urandom : opd_set[k];
   endfunction

   initial begin
      logic [31:0] pc, tg, a;
      int          k;
      bit          v, b, jj, jr, pt;
      m_reset();
      rst = 1'b1; ex_valid = 1'b0; ex_br = 1'b0; ex_j = 1'b0; ex_jr = 1'b0; ex_funct3 = 3'd0;
      ex_zero = 1'b0; ex_neg = 1'b0; ex_overflow = 1'b0; ex_carry = 1'b0;
      ex_pc = '0; ex_target = '0; ex_pred_taken = 1'b0; ex_pred_target = '0; f_pc = 32'h100;
      @(posedge clk); #1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h100);
      idle(32'h100);

      // BEQ taken at 0x100 predicted not taken, then the trained lookup.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 32'd0, 32'h100);
      idle(32'h100);
      idle(32'h100);
      // BNE not taken at 0x200 predicted taken to 0x240.
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd7, 32'd7, 32'h200, 32'h240, 1'b1, 32'h240, 32'h200);
      idle(32'h200);
      // BLT with overflow, BGEU unsigned-less, illegal funct3.
      branch(3'd4, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h204, 32'h280);
      branch(3'd7, 32'd1, 32'd2, 32'h208, 32'h2C0);
      branch(3'd2, 32'd3, 32'd3, 32'h20C, 32'h2C0);
      // JALR mispredicted target, followed by a squashed branch at the same PC.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0, 32'h300, 32'h480, 1'b1, 32'h400, 32'h300);
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 32'd1, 32'd2, 32'h300, 32'h500, 1'b0, 32'd0, 32'h300);
      idle(32'h300);
      // Saturation up then down at one index, then an aliasing lookup.
      for (int i = 0; i < 4; i++) branch(3'd0, 32'd9, 32'd9, 32'h500, 32'h540);
      for (int i = 0; i < 5; i++) branch(3'd1, 32'd9, 32'd9, 32'h500, 32'h540);
      for (int i = 0; i < 2; i++) branch(3'd0, 32'd9, 32'd9, 32'h500, 32'h540);
      idle(32'h500);
      idle(32'h100 + 32'(4 * N));
      // Reset arriving together with a mispredict suppresses its redirect.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 32'd0, 32'h100);
      idle(32'h100);
      idle(32'h300);

      for (int n = 0; n < 3000; n++) begin
         pc = rand_pc();
         k  = $urandom_range(0, 9);
         v  = ($urandom_range(0, 99) < 85);
         b  = (k <= 5);
         jj = (k == 6);
         jr = (k == 7);
         tg = ($urandom_range(0, 4) == 0) ? ($urandom & 32'hFFFF_FFFC) : tgt_set[$urandom_range(0, 3)];
         a  = rand_opd();
         if ($urandom_range(0, 1) == 1) begin
            pt = m_pred(pc);
            step(1'b0, v, b, jj, jr, 3'($urandom_range(0, 7)), a,
                 ($urandom_range(0, 2) == 0) ? a : rand_opd(), pc, tg, pt, m_tgt[m_idx(pc)], rand_pc());
         end else begin
            step(1'b0, v, b, jj, jr, 3'($urandom_range(0, 7)), a, rand_opd(), pc, tg,
                 1'($urandom_range(0, 1)), tgt_set[$urandom_range(0, 3)], rand_pc());
         end
      end
      idle(32'h100);
      idle(32'h100);
      @(negedge clk);
      check("redirect_drain", 64'(rq.size()), 64'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
